// File: rtl/store_pkg.sv
// Shared types for the store execution unit: opcode, entry and
// write-FSM states, and the queue entry layout.
package store_pkg;

    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        FREE,
        WAIT_COMMIT,
        COMMITTED,
        EXC
    } st_state_e;

    typedef enum logic {
        IDLE,
        REQ
    } mem_state_e;

    typedef struct packed {
        logic [31:0] instr_no;
        logic [31:0] ea;
        logic [31:0] data;
        st_state_e   state;
    } st_entry_t;

endpackage

// File: rtl/store_mem_writer.sv
// Drains committed head entries to memory through a req/ack handshake.
// Misaligned (no-write) entries are retired without a request.
module store_mem_writer
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  st_entry_t   head,
    input  logic        mem_wr_ack,
    output logic        mem_wr_req,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        free_head
);

    mem_state_e state;
    mem_state_e state_n;
    logic       load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                mem_wr_addr <= head.ea;
                mem_wr_data <= head.data;
            end
        end
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        free_head = 1'b0;
        unique case (state)
            IDLE: begin
                if (head.state == COMMITTED) begin
                    if (head.ea[1:0] != 2'b00) begin
                        free_head = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_wr_ack) begin
                    free_head = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_wr_req = (state == REQ);

endmodule

// File: rtl/store_exec_unit.sv
// In-order store queue: accepts SW, reports EA to the ROB, writes
// memory after commit, and forwards data to the load path.
module store_exec_unit
    import store_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_instr_no,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic        in_ready,
    output logic        op_err,
    output logic        rob_done_valid,
    output logic [31:0] rob_done_no,
    output logic        rob_done_exc,
    input  logic        rob_commit_valid,
    input  logic [31:0] rob_commit_no,
    output logic        commit_err,
    input  logic        rob_flush,
    output logic        mem_wr_req,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    input  logic        mem_wr_ack,
    input  logic [31:0] fwd_addr,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    st_entry_t   q [DEPTH];
    ptr_t        head, cptr, tail, idx;
    cnt_t        count, ucnt;
    logic        sw_op, acc, enq;
    logic        commit_hit, commit_ok, free_head;
    logic [31:0] ea;
    st_state_e   cst;

    assign in_ready   = rst && (count != cnt_t'(DEPTH)) && !rob_flush;
    assign acc        = in_valid && in_ready;
    assign sw_op      = (in_instr[31:26] == OP_SW);
    assign enq        = acc && sw_op;
    assign ea         = in_rs_val + {{16{in_instr[15]}}, in_instr[15:0]};
    assign cst        = q[cptr].state;
    assign commit_hit = (cst == WAIT_COMMIT || cst == EXC)
                        && (q[cptr].instr_no == rob_commit_no);
    assign commit_ok  = rob_commit_valid && commit_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head           <= '0;
            cptr           <= '0;
            tail           <= '0;
            count          <= '0;
            ucnt           <= '0;
            op_err         <= 1'b0;
            rob_done_valid <= 1'b0;
            rob_done_no    <= '0;
            rob_done_exc   <= 1'b0;
            commit_err     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '{instr_no: '0, ea: '0, data: '0, state: FREE};
            end
        end else begin
            op_err         <= acc && !sw_op;
            rob_done_valid <= enq;
            rob_done_no    <= enq ? in_instr_no : '0;
            rob_done_exc   <= enq && (ea[1:0] != 2'b00);
            commit_err     <= rob_commit_valid && !commit_hit;
            // later assignments win: commit overrides the flush of cptr
            if (rob_flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q[i].state == WAIT_COMMIT || q[i].state == EXC)
                        q[i].state <= FREE;
                end
            end
            if (commit_ok) begin
                q[cptr].state <= COMMITTED;
                cptr          <= cptr + ptr_t'(1);
            end
            if (enq) begin
                q[tail] <= '{
                    instr_no: in_instr_no,
                    ea:       ea,
                    data:     in_rt_val,
                    state:    (ea[1:0] != 2'b00) ? EXC : WAIT_COMMIT
                };
            end
            if (free_head) begin
                q[head].state <= FREE;
                head          <= head + ptr_t'(1);
            end
            if (rob_flush)
                tail <= commit_ok ? cptr + ptr_t'(1) : cptr;
            else if (enq)
                tail <= tail + ptr_t'(1);
            count <= count + cnt_t'(enq) - cnt_t'(free_head)
                     - (rob_flush ? ucnt - cnt_t'(commit_ok) : '0);
            ucnt  <= rob_flush ? '0
                     : ucnt + cnt_t'(enq) - cnt_t'(commit_ok);
        end
    end

    // Walk oldest to youngest so the last match is the youngest store
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + ptr_t'(i);
            if (q[idx].state != FREE && q[idx].state != EXC
                && q[idx].ea == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = q[idx].data;
            end
        end
    end

    store_mem_writer u_writer (
        .clk         (clk),
        .rst         (rst),
        .head        (q[head]),
        .mem_wr_ack  (mem_wr_ack),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .free_head   (free_head)
    );

endmodule

// File: doc/store_exec_unit.md
Name: store_exec_unit

Overview:
- Consumer end of the store-buffer issue interface. Accepts issued SW instructions with their operand values, computes the effective address, and reports completion to the ROB.
- Holds each store in an in-order queue until the ROB commits it. Only then does it perform the memory/D-cache write through a req/ack handshake.
- Also provides store-to-load forwarding lookup for the load path.

Parameters:
- DEPTH, 4, store queue entries; power of 2, 2..16.
- PTR_W, $clog2(DEPTH), queue pointer width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  issued store present
- in_instr  in  32  instruction word (SW format: op[31:26], rs[25:21], rt[20:16], offset[15:0])
- in_instr_no  in  32  instruction sequence number
- in_rs_val  in  32  base register value
- in_rt_val  in  32  store data value
- in_ready  out  1  unit can accept this cycle
- op_err  out  1  one-cycle pulse: accepted word was not SW
- rob_done_valid  out  1  one-cycle pulse: address computed
- rob_done_no  out  32  instr number of done store
- rob_done_exc  out  1  misaligned address (EA[1:0]!=0)
- rob_commit_valid  in  1  ROB commits a store
- rob_commit_no  in  32  instr number being committed
- commit_err  out  1  one-cycle pulse: commit number did not match the oldest uncommitted entry
- rob_flush  in  1  discard all uncommitted entries
- mem_wr_req  out  1  write request
- mem_wr_addr  out  32  word address (EA)
- mem_wr_data  out  32  store data
- mem_wr_ack  in  1  write accepted
- fwd_addr  in  32  load address probe
- fwd_hit  out  1  matching queued store exists
- fwd_data  out  32  data of youngest match

Behaviour:
- Queue: circular, DEPTH entries, three pointers:
  - head: oldest entry, source for memory writes.
  - cptr: next entry awaiting commit.
  - tail: next free slot.
- Entry states: FREE, WAIT_COMMIT, COMMITTED, EXC (misaligned).
- in_ready = (count < DEPTH) && !rob_flush; in_ready is 0 while rst is asserted.
- Accept happens when in_valid && in_ready at a clock edge:
  - If in_instr[31:26] != 6'b101011: not enqueued; op_err pulses on the next cycle.
  - Otherwise EA = in_rs_val + sign_extend(offset), mod 2^32. The entry is written at tail and tail advances.
  - rob_done_valid pulses on the following cycle with rob_done_no = in_instr_no and rob_done_exc = (EA[1:0]!=0). A misaligned store is enqueued as EXC.
- Commit: rob_commit_valid with rob_commit_no equal to the entry number at cptr (WAIT_COMMIT or EXC) marks it COMMITTED (an EXC entry becomes COMMITTED-no-write) and advances cptr. Any mismatch, or commit with nothing to commit, pulses commit_err and changes no state.
- Memory write FSM, states IDLE and REQ:
  - IDLE -> REQ when the head entry is COMMITTED (write). mem_wr_req rises in that cycle.
  - In REQ, mem_wr_req, mem_wr_addr and mem_wr_data are held stable until mem_wr_ack. On ack: head entry freed, head advances, FSM returns to IDLE. The next request is no earlier than the cycle after the ack.
  - A committed no-write entry is freed in IDLE in one cycle without a request.
- Flush: tail := cptr and all WAIT_COMMIT/EXC entries are freed. COMMITTED entries and any in-flight REQ complete normally.
- Simultaneous commit + flush: commit is applied first, then flush.
- Simultaneous accept + commit + write completion in one cycle: all three are legal and count is updated by net change.
- Forwarding: combinational.
  - fwd_hit = 1 if any non-FREE, non-EXC entry has EA == fwd_addr.
  - fwd_data is taken from the youngest such entry (closest to tail).
  - fwd_data = 0 when there is no hit.
- Reset (rst=0, asynchronous): all pointers and count 0, all entries FREE, FSM IDLE. Every output is 0, including in_ready, mem_wr_addr and mem_wr_data. Reset in mid-REQ abandons the write.

Decomposition:
- Package store_pkg holds:
  - OP_SW = 6'b101011
  - entry-state enum (FREE, WAIT_COMMIT, COMMITTED, EXC)
  - mem FSM enum (IDLE, REQ)
  - st_entry_t struct (instr_no, ea, data, state)
- One sub-module, store_mem_writer: the IDLE/REQ handshake FSM driving the mem_wr_* ports from the head entry and returning a free_head pulse.

Test Plan:
- Single store: accept SW, rs=0x1000, offset=0xFFFC, rt=0xDEAD, instr_no=5 -> rob_done pulse next cycle with no=5, exc=0. After commit 5: mem_wr_addr=0x0FFC and data=0xDEAD, held through 3 no-ack cycles; on ack the queue is empty.
- Fill/full: 4 accepts with no commits -> in_ready=0. Commit the first and ack it -> in_ready=1 the cycle after the free.
- Out-of-order commit: queue holds nos 7 and 8; commit 8 -> commit_err pulse and no write. Then commit 7, then 8 -> writes in order 7, 8.
- Flush: entries 1 (COMMITTED, REQ in flight) and 2, 3 (WAIT_COMMIT) + rob_flush -> write for 1 completes on ack; 2 and 3 are gone; tail == cptr.
- Misaligned and bad opcode: EA=0x1002 -> rob_done_exc=1; commit -> no mem_wr_req. A LW opcode (0x23) -> op_err pulse and count unchanged.
- Forwarding + reset: two queued stores to 0x2000 with data 0x11 then 0x22 -> fwd_hit=1, fwd_data=0x22. Assert rst mid-REQ -> mem_wr_req=0 immediately and fwd_hit=0.
